// File: rtl/fp_pkg.sv
// Shared definitions for the FP write-back path: flag layout, NaN-box constant,
// the queued entry type and the result formatting helpers.
package fp_pkg;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [15:0] NANBOX_H = 16'hFFFF;

    typedef struct packed {
        logic [31:0]       data;
        logic [4:0]        rd;
        logic [FLAG_W-1:0] flags;
    } wb_entry_t;

    // Half results are NaN-boxed so a later single-precision read sees a qNaN.
    function automatic logic [31:0] box_result(input logic mode_fp, input logic [31:0] res);
        return mode_fp ? res : {NANBOX_H, res[15:0]};
    endfunction

    function automatic logic flags_any(input logic [FLAG_W-1:0] f);
        return f[FLAG_NV] | f[FLAG_DZ] | f[FLAG_OF] | f[FLAG_UF] | f[FLAG_NX];
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with a registered head output; a push into an empty FIFO is
// visible on head_dat_o one cycle later. Push is dropped when full, pop when empty.
module fp_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_dat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign rd_next    = rd_ptr_q + AW'(1);
    assign count_o    = count_q;
    assign head_dat_o = head_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_next           : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        // Head register tracks mem[rd_ptr]; bypass the array when the
        // incoming word becomes the new head immediately.
        head_d = head_q;
        if (do_pop && count_q > (AW+1)'(1))
            head_d = mem_q[rd_next];
        else if (do_push && (empty_o || (count_q == (AW+1)'(1) && do_pop)))
            head_d = push_dat_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/fp_wb_stage.sv
// FP multiply write-back stage: formats results, queues them (latency 1 when empty),
// and accumulates sticky flags and an exception count at retirement. in_ready = not full.
module fp_wb_stage
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic [FLAG_W-1:0]          in_flags,
    input  logic                       in_mode_fp,
    input  logic [4:0]                 in_rd,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [4:0]                 wb_rd,
    output logic [FLAG_W-1:0]          fflags,
    input  logic                       fflags_clr,
    output logic [CNT_W-1:0]           exc_count,
    output logic [$clog2(DEPTH):0]     occupancy
);

    wb_entry_t         in_entry;
    wb_entry_t         head_entry;
    logic              accept, retire;
    logic              fifo_full, fifo_empty;
    logic [FLAG_W-1:0] fflags_q, fflags_d;
    logic [CNT_W-1:0]  exc_q, exc_d;

    assign in_ready = !fifo_full;
    assign wb_valid = !fifo_empty;
    assign accept   = in_valid && in_ready;
    assign retire   = wb_valid && wb_ready;

    always_comb begin
        in_entry.data  = box_result(in_mode_fp, in_result);
        in_entry.rd    = in_rd;
        in_entry.flags = in_flags;
    end

    fp_sync_fifo #(
        .W     ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .push_dat_i (in_entry),
        .pop_i      (retire),
        .head_dat_o (head_entry),
        .count_o    (occupancy),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign wb_data = head_entry.data;
    assign wb_rd   = head_entry.rd;

    always_comb begin
        // Clear first so a coinciding retirement still lands in the sticky flags.
        fflags_d = fflags_clr ? '0 : fflags_q;
        if (retire)
            fflags_d = fflags_d | head_entry.flags;
        exc_d = exc_q;
        if (retire && flags_any(head_entry.flags) && exc_q != '1)
            exc_d = exc_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fflags_q <= '0;
            exc_q    <= '0;
        end else begin
            fflags_q <= fflags_d;
            exc_q    <= exc_d;
        end
    end

    assign fflags    = fflags_q;
    assign exc_count = exc_q;

endmodule

// File: tb/tb_fp_wb_stage.sv
// Directed bench for fp_wb_stage: a default instance plus a CNT_W=2 instance on the
// same stimulus for counter saturation.
module tb_fp_wb_stage;

    logic        clk, reset;
    logic        in_valid, in_mode_fp, wb_ready, fflags_clr;
    logic [31:0] in_result;
    logic [4:0]  in_flags, in_rd;

    logic        in_ready, wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd, fflags;
    logic [15:0] exc_count;
    logic [2:0]  occupancy;

    logic        in_ready2, wb_valid2;
    logic [31:0] wb_data2;
    logic [4:0]  wb_rd2, fflags2;
    logic [1:0]  exc_count2;
    logic [2:0]  occupancy2;

    int tests = 0;
    int fails = 0;
    int exc_m;
    logic [4:0] ff_m;

    fp_wb_stage #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_mode_fp(in_mode_fp), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .fflags(fflags), .fflags_clr(fflags_clr), .exc_count(exc_count), .occupancy(occupancy)
    );

    fp_wb_stage #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_result(in_result), .in_flags(in_flags), .in_mode_fp(in_mode_fp), .in_rd(in_rd),
        .wb_valid(wb_valid2), .wb_ready(wb_ready), .wb_data(wb_data2), .wb_rd(wb_rd2),
        .fflags(fflags2), .fflags_clr(fflags_clr), .exc_count(exc_count2), .occupancy(occupancy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] res;
        logic [4:0]  flags;
        logic [4:0]  rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [31:0] res, input logic [4:0] fl,
                         input logic [4:0] rd);
        in_valid   = 1'b1;
        in_mode_fp = mode;
        in_result  = res;
        in_flags   = fl;
        in_rd      = rd;
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h3F800000, 5'b00000, 5'd3,  32'h3F800000};
        vecs[1] = '{1'b0, 32'h00003C00, 5'b00000, 5'd7,  32'hFFFF3C00};
        vecs[2] = '{1'b0, 32'hDEADBEEF, 5'b00001, 5'd31, 32'hFFFFBEEF};
        vecs[3] = '{1'b1, 32'h7F800000, 5'b00100, 5'd0,  32'h7F800000};
        vecs[4] = '{1'b0, 32'h12347E00, 5'b10000, 5'd15, 32'hFFFF7E00};
        vecs[5] = '{1'b1, 32'h00000001, 5'b00010, 5'd1,  32'h00000001};

        reset = 1'b1; in_valid = 1'b0; in_mode_fp = 1'b0; in_result = '0;
        in_flags = '0; in_rd = '0; wb_ready = 1'b0; fflags_clr = 1'b0;
        step(); step();
        reset = 1'b0;

        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_fflags", 32'(fflags), 0);
        chk("rst_exc", 32'(exc_count), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);

        // Single push/retire per vector; pointers wrap past DEPTH.
        exc_m = 0; ff_m = '0;
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].mode, vecs[i].res, vecs[i].flags, vecs[i].rd);
            step();
            in_valid = 1'b0;
            chk("vec_wb_valid", 32'(wb_valid), 1);
            chk("vec_wb_data", wb_data, vecs[i].exp_data);
            chk("vec_wb_rd", 32'(wb_rd), 32'(vecs[i].rd));
            chk("vec_occ1", 32'(occupancy), 1);
            chk("vec_fflags_pre", 32'(fflags), 32'(ff_m));
            step();
            ff_m = ff_m | vecs[i].flags;
            if (vecs[i].flags != 0) exc_m++;
            chk("vec_occ0", 32'(occupancy), 0);
            chk("vec_fflags", 32'(fflags), 32'(ff_m));
            chk("vec_exc", 32'(exc_count), 32'(exc_m));
            chk("vec_exc_sat", 32'(exc_count2), 32'((exc_m > 3) ? 3 : exc_m));
        end

        // Backpressure: five pushes into a depth-4 queue.
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 5'b0, 5'(10 + i));
            chk("bp_in_ready", 32'(in_ready), (i < 4) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        chk("bp_occ_full", 32'(occupancy), 4);
        chk("bp_head_stable", 32'(wb_rd), 10);
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_order_rd", 32'(wb_rd), 32'(10 + i));
            chk("bp_order_data", wb_data, 32'hA0 + 32'(i));
            step();
        end
        chk("bp_drained", 32'(occupancy), 0);
        chk("bp_wb_valid", 32'(wb_valid), 0);

        // Full while retiring: offered entry must be refused.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 5'b0, 5'(20 + i));
            step();
        end
        drive(1'b1, 32'h2FF, 5'b0, 5'd24);
        wb_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_retire_occ", 32'(occupancy), 3);
        for (int i = 1; i < 4; i++) begin
            chk("full_retire_rd", 32'(wb_rd), 32'(20 + i));
            step();
        end
        chk("full_retire_empty", 32'(occupancy), 0);

        // Simultaneous accept and retire at occupancy 1.
        drive(1'b1, 32'h300, 5'b0, 5'd25);
        step();
        drive(1'b1, 32'h301, 5'b0, 5'd26);
        step();
        in_valid = 1'b0;
        chk("acc_ret_occ", 32'(occupancy), 1);
        chk("acc_ret_rd", 32'(wb_rd), 26);
        step();
        chk("acc_ret_empty", 32'(occupancy), 0);

        // Flags: accumulate only on retirement; clear coinciding with retirement.
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_fflags", 32'(fflags), 0);
        chk("clr_keeps_exc", 32'(exc_count), 32'(exc_m));
        wb_ready = 1'b0;
        drive(1'b1, 32'h1, 5'b00100, 5'd1);
        step();
        drive(1'b1, 32'h2, 5'b00001, 5'd2);
        step();
        in_valid = 1'b0;
        chk("flags_not_on_accept", 32'(fflags), 0);
        wb_ready = 1'b1;
        step(); step();
        exc_m += 2;
        chk("flags_accum", 32'(fflags), 32'(5'b00101));
        chk("flags_exc", 32'(exc_count), 32'(exc_m));
        wb_ready = 1'b0;
        drive(1'b1, 32'h3, 5'b10000, 5'd3);
        step();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        exc_m++;
        chk("clr_with_retire", 32'(fflags), 32'(5'b10000));
        chk("exc_after_clr", 32'(exc_count), 32'(exc_m));
        chk("exc_saturated", 32'(exc_count2), 3);

        // Reset with three queued entries and every other control active.
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 5'b01000, 5'(i + 4));
            step();
        end
        chk("pre_rst_occ", 32'(occupancy), 3);
        reset = 1'b1; wb_ready = 1'b1; fflags_clr = 1'b1;
        drive(1'b1, 32'h4FF, 5'b00010, 5'd9);
        step();
        reset = 1'b0; in_valid = 1'b0; fflags_clr = 1'b0; wb_ready = 1'b0;
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 0);
        chk("mid_rst_fflags", 32'(fflags), 0);
        chk("mid_rst_exc", 32'(exc_count), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_wb_data", wb_data, 0);
        step();
        chk("post_rst_occ", 32'(occupancy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
